// File: rtl/tnn_neuron_scheduler_pkg.sv
// Shared types, defaults and operand-packing helper for the TNN neuron scheduler.
package tnn_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  localparam int IN_W_DEFAULT = 3;

  // Bit offset of a neuron's operand inside a packed operand vector.
  function automatic int unsigned op_lsb(input int unsigned neuron, input int unsigned width);
    return neuron * width;
  endfunction

endpackage

// File: rtl/tnn_neuron_scheduler_if.sv
// Job/result handshake, packed operand bus and shared-core port bundle.
interface tnn_neuron_scheduler_if
  import tnn_sched_pkg::*;
#(
  parameter int NUM_NEURONS = 6,
  parameter int IN_W        = IN_W_DEFAULT
);

  logic                        start_valid;
  logic                        start_ready;
  logic [NUM_NEURONS*IN_W-1:0] op_a;
  logic [NUM_NEURONS*IN_W-1:0] op_b;
  logic [NUM_NEURONS*IN_W-1:0] op_c;
  logic [IN_W-1:0]             core_a;
  logic [IN_W-1:0]             core_b;
  logic [IN_W-1:0]             core_c;
  logic                        core_out;
  logic                        res_valid;
  logic                        res_ready;
  logic [NUM_NEURONS-1:0]      res_bits;
  logic                        busy;

  modport slave (
    input  start_valid, op_a, op_b, op_c, core_out, res_ready,
    output start_ready, core_a, core_b, core_c, res_valid, res_bits, busy
  );

  modport master (
    output start_valid, op_a, op_b, op_c, core_out, res_ready,
    input  start_ready, core_a, core_b, core_c, res_valid, res_bits, busy
  );

endinterface

// File: rtl/tnn_neuron_scheduler_operand_bank.sv
// Captured operand registers plus the registered per-neuron mux feeding the shared core.
module tnn_operand_bank
  import tnn_sched_pkg::*;
#(
  parameter int NUM_NEURONS = 6,
  parameter int IN_W        = IN_W_DEFAULT,
  parameter int IDX_W       = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_load,
  input  logic                        i_sel_valid,
  input  logic [IDX_W-1:0]            i_sel_idx,
  input  logic [NUM_NEURONS*IN_W-1:0] i_op_a,
  input  logic [NUM_NEURONS*IN_W-1:0] i_op_b,
  input  logic [NUM_NEURONS*IN_W-1:0] i_op_c,
  output logic [IN_W-1:0]             o_core_a,
  output logic [IN_W-1:0]             o_core_b,
  output logic [IN_W-1:0]             o_core_c
);

  // Slots are padded to a power of two so any idx value selects a defined (zero) entry.
  localparam int DEPTH = 2 ** IDX_W;

  logic [DEPTH*IN_W-1:0] w_a_ext;
  logic [DEPTH*IN_W-1:0] w_b_ext;
  logic [DEPTH*IN_W-1:0] w_c_ext;
  logic [IN_W-1:0]       r_a [DEPTH];
  logic [IN_W-1:0]       r_b [DEPTH];
  logic [IN_W-1:0]       r_c [DEPTH];
  logic [IN_W-1:0]       r_core_a;
  logic [IN_W-1:0]       r_core_b;
  logic [IN_W-1:0]       r_core_c;

  assign w_a_ext = (DEPTH*IN_W)'(i_op_a);
  assign w_b_ext = (DEPTH*IN_W)'(i_op_b);
  assign w_c_ext = (DEPTH*IN_W)'(i_op_c);

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
        r_c[i] <= '0;
      end else if (i_load) begin
        r_a[i] <= w_a_ext[op_lsb(i, IN_W) +: IN_W];
        r_b[i] <= w_b_ext[op_lsb(i, IN_W) +: IN_W];
        r_c[i] <= w_c_ext[op_lsb(i, IN_W) +: IN_W];
      end
    end
  end

  // Neuron 0 comes straight from the inputs on the load edge; later neurons from the bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_core_a <= '0;
      r_core_b <= '0;
      r_core_c <= '0;
    end else if (i_load) begin
      r_core_a <= i_op_a[IN_W-1:0];
      r_core_b <= i_op_b[IN_W-1:0];
      r_core_c <= i_op_c[IN_W-1:0];
    end else if (i_sel_valid) begin
      r_core_a <= r_a[i_sel_idx];
      r_core_b <= r_b[i_sel_idx];
      r_core_c <= r_c[i_sel_idx];
    end else begin
      r_core_a <= '0;
      r_core_b <= '0;
      r_core_c <= '0;
    end
  end

  assign o_core_a = r_core_a;
  assign o_core_b = r_core_b;
  assign o_core_c = r_core_c;

endmodule

// File: rtl/tnn_neuron_scheduler.sv
// Time-multiplexes one shared TNN neuron core over NUM_NEURONS neurons per job,
// returning the collected 1-bit results over a valid/ready handshake.
module tnn_neuron_scheduler
  import tnn_sched_pkg::*;
#(
  parameter int NUM_NEURONS = 6,
  parameter int IN_W        = IN_W_DEFAULT
) (
  input logic                   clk,
  input logic                   rst,
  tnn_neuron_scheduler_if.slave bus
);

  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  logic [1:0]             r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [NUM_NEURONS-1:0] r_res;
  logic                   w_load;
  logic                   w_sel_valid;
  logic [IDX_W-1:0]       w_sel_idx;

  // The core operands for cycle idx+1 are registered during cycle idx.
  always_comb begin
    w_load      = 1'b0;
    w_sel_valid = 1'b0;
    w_sel_idx   = r_idx + IDX_W'(1);
    case (r_state)
      ST_IDLE: w_load      = bus.start_valid;
      ST_RUN:  w_sel_valid = (r_idx != LAST_IDX);
      default: w_sel_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_res   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start_valid) begin
            r_state <= ST_RUN;
            r_idx   <= '0;
            r_res   <= '0;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NUM_NEURONS; i++) begin
            if (r_idx == IDX_W'(i)) begin
              r_res[i] <= bus.core_out;
            end
          end
          if (r_idx == LAST_IDX) begin
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
          r_res   <= '0;
        end
      endcase
    end
  end

  tnn_operand_bank #(
    .NUM_NEURONS (NUM_NEURONS),
    .IN_W        (IN_W),
    .IDX_W       (IDX_W)
  ) u_bank (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_sel_valid (w_sel_valid),
    .i_sel_idx   (w_sel_idx),
    .i_op_a      (bus.op_a),
    .i_op_b      (bus.op_b),
    .i_op_c      (bus.op_c),
    .o_core_a    (bus.core_a),
    .o_core_b    (bus.core_b),
    .o_core_c    (bus.core_c)
  );

  assign bus.start_ready = (r_state == ST_IDLE);
  assign bus.res_valid   = (r_state == ST_DONE);
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.res_bits    = r_res;

endmodule
